// File: rtl/jtdsp16_prog_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_prog_pkg                                                     |
// | Shared FSM encoding and constants for the DSP16 program loader.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package jtdsp16_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CKSUM = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Trailer length following the image when the checksum option is built in
  localparam int CKSUM_BYTES = 2;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_CKSUM) || (s == ST_HOLD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtdsp16_prog_cksum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_prog_cksum                                                   |
// | 16-bit modulo sum of image bytes and comparison with a two-byte,     |
// | LSB-first trailer. Only built when JTDSP16_PROG_CKSUM_EN is defined. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`ifdef JTDSP16_PROG_CKSUM_EN
module jtdsp16_prog_cksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic       lsb_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [15:0] sum_q;
  logic [7:0]  lsb_q;

  // Accumulate image bytes and capture the trailer low byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      lsb_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
      lsb_q <= '0;
    end else begin
      if (add_i) sum_q <= sum_q + {8'h00, data_i};
      if (lsb_i) lsb_q <= data_i;
    end
  end

  // Valid while the trailer high byte is on data_i
  assign match_o = ({data_i, lsb_q} == sum_q);

endmodule
`endif
`default_nettype wire

// File: rtl/jtdsp16_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_prog                                                         |
// | Streams a byte-wide download into the DSP16 program ROM and holds    |
// | the DSP in reset until the image is complete.                        |
// | Optional trailer checksum: define JTDSP16_PROG_CKSUM_EN.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module jtdsp16_prog
  import jtdsp16_prog_pkg::*;
#(
  parameter int AW       = 13,
  parameter int RST_HOLD = 4,
  parameter int AUTORUN  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dl_start,
  input  logic [7:0]    dl_data,
  input  logic          dl_valid,
  output logic          dl_ready,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          dsp_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Hold counter must reach RST_HOLD and also be preloadable with 1
  localparam int          HW       = $clog2(RST_HOLD + 2);
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      data_q;
  logic            w_accept;
  logic            w_img_acc;

  assign dl_ready  = ((state_q == ST_LOAD) || (state_q == ST_CKSUM)) && !dl_start;
  assign w_accept  = dl_valid && dl_ready;
  assign w_img_acc = w_accept && (state_q == ST_LOAD);

`ifdef JTDSP16_PROG_CKSUM_EN
  localparam logic [AW-1:0] TR_LAST = AW'(CKSUM_BYTES - 1);

  logic w_tr_acc;
  logic w_ck_match;

  assign w_tr_acc = w_accept && (state_q == ST_CKSUM);

  jtdsp16_prog_cksum u_cksum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (dl_start),
    .add_i   (w_img_acc),
    .lsb_i   (w_tr_acc && (cnt_q[AW-1:0] == '0)),
    .data_i  (dl_data),
    .match_o (w_ck_match)
  );

  assign err = (state_q == ST_ERR);
`else
  assign err = 1'b0;
`endif

  // State, byte counter and hold counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic; dl_start overrides everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    if (dl_start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
`ifdef JTDSP16_PROG_CKSUM_EN
              state_d = ST_CKSUM;
`else
              // The first HOLD cycle carries the final prog_we, so start at 0
              state_d = ST_HOLD;
              hcnt_d  = '0;
`endif
            end
          end
        end
`ifdef JTDSP16_PROG_CKSUM_EN
        ST_CKSUM: begin
          if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q[AW-1:0] == TR_LAST) begin
              // The final prog_we is already behind us, so every HOLD cycle counts
              state_d = w_ck_match ? ST_HOLD : ST_ERR;
              hcnt_d  = HW'(1);
            end
          end
        end
`endif
        ST_HOLD: begin
          if (hcnt_q >= HW'(RST_HOLD)) state_d = ST_DONE;
          else                         hcnt_d  = hcnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered ROM write port: one strobe per accepted image byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= w_img_acc;
      if (w_img_acc) begin
        addr_q <= cnt_q[AW-1:0];
        data_q <= dl_data;
      end
    end
  end

  assign prog_we   = we_q;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign dsp_rst   = !((state_q == ST_DONE) || ((AUTORUN != 0) && (state_q == ST_IDLE)));

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jtdsp16_prog                                                      |
// | Self-checking bench: per-cycle vector table on a small AUTORUN       |
// | instance, directed sequences plus write scoreboard on the default.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_jtdsp16_prog;

  localparam int AW = 13;
  localparam int NB = 1 << AW;
`ifdef JTDSP16_PROG_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int TR  = CK ? 2 : 0;
  localparam int LAT = CK ? 6 : 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic          dl_start = 1'b0, dl_valid = 1'b0;
  logic [7:0]    dl_data = 8'h00;
  logic          dl_ready, prog_we, dsp_rst, busy, done, err;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;

  jtdsp16_prog #(.AW(AW), .RST_HOLD(4), .AUTORUN(0)) u_dut (
    .clk(clk), .rst(rst), .dl_start(dl_start), .dl_data(dl_data),
    .dl_valid(dl_valid), .dl_ready(dl_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_we(prog_we), .dsp_rst(dsp_rst),
    .busy(busy), .done(done), .err(err)
  );

  // small AUTORUN instance
  logic       a_start = 1'b0, a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_rdy, a_we, a_drst, a_busy, a_done, a_err;
  logic [1:0] a_addr;
  logic [7:0] a_pdata;

  jtdsp16_prog #(.AW(2), .RST_HOLD(2), .AUTORUN(1)) u_auto (
    .clk(clk), .rst(rst), .dl_start(a_start), .dl_data(a_data),
    .dl_valid(a_valid), .dl_ready(a_rdy), .prog_addr(a_addr),
    .prog_data(a_pdata), .prog_we(a_we), .dsp_rst(a_drst),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard state
  bit          img_ones = 1'b0;
  logic [15:0] trailer  = 16'h0000;
  int          exp_addr = 0, wr_count = 0, run_len = 0, max_run = 0;
  int          cyc = 0, last_we_cyc = 0, sent = 0;
  bit          acc_prev = 1'b0;

  function automatic logic [7:0] fimg(input int i);
    return img_ones ? 8'h01 : 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] byte_for(input int i);
    if (i < NB)  return fimg(i);
    if (i == NB) return trailer[7:0];
    return trailer[15:8];
  endfunction

  // write monitor for the main instance
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      acc_prev = 1'b0;
    end else begin
      chk("we_follows_accept", 32'(prog_we), 32'(acc_prev));
      if (prog_we) begin
        chk("wr_addr", 32'(prog_addr), 32'(exp_addr));
        chk("wr_data", 32'(prog_data), 32'(fimg(exp_addr)));
        exp_addr++;
        wr_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        last_we_cyc = cyc;
      end else begin
        run_len = 0;
      end
      acc_prev = dl_valid && dl_ready;
    end
  end

  task automatic start_dl(input bit chk_busy);
    @(negedge clk);
    dl_start = 1'b1;
    dl_valid = 1'b1;
    #1;
    chk("ready_masked_on_start", 32'(dl_ready), 32'd0);
    if (chk_busy) begin
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_dsp_rst", 32'(dsp_rst), 32'd1);
    end
    @(negedge clk);
    dl_start = 1'b0;
    dl_valid = 1'b0;
    exp_addr = 0; wr_count = 0; run_len = 0; max_run = 0; sent = 0;
  endtask

  task automatic feed(input int upto, input bit rnd);
    int guard = 0;
    while (sent < upto && guard < 40000) begin
      @(negedge clk);
      dl_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dl_data  = byte_for(sent);
      #1;
      if (dl_valid && dl_ready) sent++;
      guard++;
    end
    chk("feed_in_budget", 32'(sent >= upto), 32'd1);
  endtask

  task automatic wait_end(input bit exp_done, input int exp_lat, input bit chk_lat);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      #3;
      if (done || err) seen = 1'b1;
      else chk("dsp_rst_before_end", 32'(dsp_rst), 32'd1);
    end
    chk("end_reached", 32'(seen), 32'd1);
    chk("done_flag", 32'(done), 32'(exp_done));
    chk("err_flag", 32'(err), 32'(!exp_done));
    chk("dsp_rst_at_end", 32'(dsp_rst), 32'(!exp_done));
    chk("busy_at_end", 32'(busy), 32'd0);
    if (chk_lat) chk("hold_latency", 32'(cyc - last_we_cyc), 32'(exp_lat));
  endtask

  // per-cycle vectors for the AW=2, RST_HOLD=2, AUTORUN=1 instance
  typedef struct packed {
    logic       s, v;
    logic [7:0] d;
    logic       rdy, we;
    logic [1:0] a;
    logic [7:0] pd;
    logic       drst, bsy, dn;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic s, v, input logic [7:0] d, input logic rdy, we,
                     input logic [1:0] a, input logic [7:0] pd, input logic drst, bsy, dn);
    vec_t r;
    r = {s, v, d, rdy, we, a, pd, drst, bsy, dn};
    tbl.push_back(r);
  endtask

  initial begin
    logic [15:0] s16;
    int w0;

    // reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 32'(prog_we), 32'd0);
    chk("rst_addr", 32'(prog_addr), 32'd0);
    chk("rst_data", 32'(prog_data), 32'd0);
    chk("rst_flags", 32'({dl_ready, busy, done, err}), 32'd0);
    chk("rst_dsp_rst", 32'(dsp_rst), 32'd1);
    chk("rst_dsp_rst_autorun", 32'(a_drst), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_dsp_rst", 32'(dsp_rst), 32'd1);
    chk("idle_flags", 32'({dl_ready, busy, done, err}), 32'd0);

    // vector table: s v d | rdy we a pd drst busy done
    row(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    row(1, 1, 8'hAA, 0, 0, 0, 8'h00, 0, 0, 0);
    row(0, 1, 8'h11, 1, 0, 0, 8'h00, 1, 1, 0);
    row(0, 0, 8'h99, 1, 1, 0, 8'h11, 1, 1, 0);
    row(0, 1, 8'h22, 1, 0, 0, 8'h11, 1, 1, 0);
    row(0, 1, 8'h33, 1, 1, 1, 8'h22, 1, 1, 0);
    row(0, 1, 8'h44, 1, 1, 2, 8'h33, 1, 1, 0);
    row(0, 1, 8'hAA, CK, 1, 3, 8'h44, 1, 1, 0);
    if (CK) row(0, 1, 8'h00, 1, 0, 3, 8'h44, 1, 1, 0);
    row(0, 1, 8'h77, 0, 0, 3, 8'h44, 1, 1, 0);
    row(0, 1, 8'h77, 0, 0, 3, 8'h44, 1, 1, 0);
    row(0, 1, 8'h77, 0, 0, 3, 8'h44, 0, 0, 1);
    row(0, 0, 8'h00, 0, 0, 3, 8'h44, 0, 0, 1);
    row(1, 1, 8'h55, 0, 0, 3, 8'h44, 0, 0, 1);
    row(0, 1, 8'h66, 1, 0, 3, 8'h44, 1, 1, 0);
    row(0, 0, 8'h00, 1, 1, 0, 8'h66, 1, 1, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      a_start = tbl[k].s;
      a_valid = tbl[k].v;
      a_data  = tbl[k].d;
      #1;
      chk($sformatf("vec_row%0d", k),
          32'({a_rdy, a_we, a_addr, a_pdata, a_drst, a_busy, a_done, a_err}),
          32'({tbl[k].rdy, tbl[k].we, tbl[k].a, tbl[k].pd, tbl[k].drst, tbl[k].bsy, tbl[k].dn, 1'b0}));
    end
    @(negedge clk);
    a_valid = 1'b0;

    // full-speed download
    img_ones = 1'b0;
    s16 = '0;
    for (int i = 0; i < NB; i++) s16 += 16'(fimg(i));
    trailer = s16;
    start_dl(1'b0);
    feed(NB + TR, 1'b0);
    wait_end(1'b1, LAT, 1'b1);
    chk("full_writes", 32'(wr_count), 32'(NB));
    chk("full_consecutive", 32'(max_run), 32'(NB));
    repeat (3) begin
      @(negedge clk);
      dl_valid = 1'b1;
      #3;
      chk("done_sticky", 32'(done), 32'd1);
    end
    @(negedge clk);
    dl_valid = 1'b0;

    // 50% random valid
    start_dl(1'b0);
    feed(NB + TR, 1'b1);
    wait_end(1'b1, 0, 1'b0);
    chk("random_writes", 32'(wr_count), 32'(NB));

    // restart at byte 1000
    start_dl(1'b0);
    feed(1000, 1'b0);
    start_dl(1'b1);
    #1;
    chk("restart_busy_after", 32'(busy), 32'd1);
    chk("restart_dsp_rst_after", 32'(dsp_rst), 32'd1);
    feed(NB + TR, 1'b0);
    wait_end(1'b1, LAT, 1'b1);
    chk("restart_writes", 32'(wr_count), 32'(NB));

    // asynchronous reset at byte 500
    start_dl(1'b0);
    feed(500, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("midrst_we", 32'(prog_we), 32'd0);
    chk("midrst_addr", 32'(prog_addr), 32'd0);
    chk("midrst_data", 32'(prog_data), 32'd0);
    chk("midrst_flags", 32'({dl_ready, busy, done, err}), 32'd0);
    chk("midrst_dsp_rst", 32'(dsp_rst), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dl_valid = 1'b1;
    w0 = wr_count;
    repeat (20) @(negedge clk);
    #3;
    chk("post_rst_no_writes", 32'(wr_count), 32'(w0));
    chk("post_rst_idle", 32'({dl_ready, busy, dsp_rst}), 32'b001);
    dl_valid = 1'b0;

`ifdef JTDSP16_PROG_CKSUM_EN
    // checksum pass and fail on an all-0x01 image
    img_ones = 1'b1;
    trailer  = 16'h2000;
    start_dl(1'b0);
    feed(NB + TR, 1'b0);
    wait_end(1'b1, LAT, 1'b1);
    trailer  = 16'h2001;
    start_dl(1'b0);
    feed(NB + TR, 1'b0);
    wait_end(1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #3;
    chk("err_sticky", 32'({err, dsp_rst, done}), 32'b110);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtdsp16_prog.md
JTDSP16_PROG -- requirements
Module: jtdsp16_prog

Interface
REQ-001 SHALL have parameter AW, default 13, meaning the byte-address width of the program ROM image (2^AW bytes, LSB at even address).
REQ-002 SHALL have parameter RST_HOLD, default 4, meaning the number of cycles dsp_rst stays high after the last write.
REQ-003 SHALL have parameter AUTORUN, default 0, meaning that when 1, dsp_rst is low in IDLE after reset (firmware preloaded).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port dl_start, input, 1 bit: single-cycle pulse that begins or restarts a download.
REQ-007 SHALL have port dl_data, input, 8 bits: download byte.
REQ-008 SHALL have port dl_valid, input, 1 bit: dl_data is valid.
REQ-009 SHALL have port dl_ready, output, 1 bit: the block accepts a byte; transfer occurs when dl_valid&dl_ready.
REQ-010 SHALL have port prog_addr, output, AW bits: ROM programming byte address.
REQ-011 SHALL have port prog_data, output, 8 bits: ROM programming byte.
REQ-012 SHALL have port prog_we, output, 1 bit: ROM write strobe, one cycle per byte.
REQ-013 SHALL have port dsp_rst, output, 1 bit: holds the DSP core in reset.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD, CKSUM and HOLD.
REQ-015 SHALL have port done, output, 1 bit: high in DONE only.
REQ-016 SHALL have port err, output, 1 bit: checksum mismatch flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CKSUM, HOLD, DONE, ERR.
REQ-018 SHALL, on dl_start in any state: next state LOAD, byte counter 0, sum 0, err 0, dsp_rst 1; dl_start takes priority over every other event that cycle.
REQ-019 SHALL drive dl_ready=1 only in LOAD and CKSUM (not on the cycle dl_start is sampled).
REQ-020 SHALL, for each byte accepted in LOAD at counter N, assert prog_we=1, prog_addr=N, prog_data=byte exactly one cycle later (registered, latency 1), and increment N.
REQ-021 SHALL sustain one byte per cycle with dl_valid held high; dl_valid low stalls without any write.
REQ-022 SHALL hold prog_addr/prog_data stable and prog_we=0 whenever no byte was accepted the previous cycle.
REQ-023 SHALL leave LOAD after accepting byte 2^AW-1 (counter wrap is never written; the counter is AW+1 bits or the terminal count is detected before wrap).
REQ-024 SHALL, in HOLD, count RST_HOLD cycles starting after the final prog_we cycle, then enter DONE.
REQ-025 SHALL drive dsp_rst=0 only in DONE, and in IDLE when AUTORUN=1.
REQ-026 SHALL keep DONE and ERR until dl_start or rst.
REQ-027 SHALL ignore dl_valid outside LOAD/CKSUM.

Reset
REQ-028 SHALL, on rst high, asynchronously force: state IDLE, counter 0, prog_we 0, prog_addr 0, prog_data 0, dl_ready 0, busy 0, done 0, err 0, dsp_rst = (AUTORUN ? 0 : 1).
REQ-029 SHALL, on rst mid-download, abandon the download; the partial ROM image is not restored and a new dl_start is needed.

Configuration
REQ-030 SHALL, with JTDSP16_PROG_CKSUM_EN defined, accumulate the 16-bit modulo-2^16 sum of all 2^AW image bytes, enter CKSUM after the last image byte, and accept 2 more bytes (LSB first) without prog_we; match -> HOLD, mismatch -> ERR (err=1, dsp_rst=1).
REQ-031 SHALL, without JTDSP16_PROG_CKSUM_EN, omit the CKSUM/ERR logic, go LOAD -> HOLD directly, and tie err to 0.

Structure
REQ-032 SHALL place FSM state encodings and the checksum byte count (2) in shared package jtdsp16_prog_pkg.
REQ-033 SHALL implement the sum accumulator and compare as sub-module jtdsp16_prog_cksum, instantiated only when JTDSP16_PROG_CKSUM_EN is defined.

Verification
REQ-034 SHALL cover: reset, then dl_start with 8192 bytes, dl_valid held high -> prog_we high 8192 consecutive cycles, addresses 0..8191, done after 4 HOLD cycles, dsp_rst falls with done.
REQ-035 SHALL cover: dl_valid toggled randomly at 50% -> exactly 8192 writes, no address gaps or repeats, prog_we never without a prior accepted byte.
REQ-036 SHALL cover: dl_start pulsed at byte 1000 -> next write at address 0, dsp_rst stays 1, busy stays 1.
REQ-037 SHALL cover: rst asserted at byte 500 -> outputs at reset values the same cycle; no writes until the next dl_start.
REQ-038 SHALL cover (CKSUM_EN): image of all 0x01 with trailer 0x00,0x20 -> DONE; trailer 0x01,0x20 -> ERR, err=1, dsp_rst=1.
REQ-039 SHALL cover: AUTORUN=1 -> dsp_rst=0 after reset, 1 during a download, 0 in DONE.
